// File: rtl/alu_issue_queue.sv
// alu_issue_queue: age-ordered, compacting issue queue for the two ALU pipes.
// Entries wait until both source tags are ready, are woken by the ALU result
// broadcasts, and the two oldest ready entries are offered to ALU0/ALU1.
module alu_issue_queue #(
   parameter int DEPTH     = 8,
   parameter int TAG_W     = 6,
   parameter int PAYLOAD_W = 128
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       enq_valid_i,
   output logic                       enq_ready_o,
   input  logic [TAG_W-1:0]           enq_src0_tag_i,
   input  logic [TAG_W-1:0]           enq_src1_tag_i,
   input  logic                       enq_src0_rdy_i,
   input  logic                       enq_src1_rdy_i,
   input  logic [PAYLOAD_W-1:0]       enq_payload_i,
   input  logic                       wake0_en_i,
   input  logic                       wake1_en_i,
   input  logic [TAG_W-1:0]           wake0_tag_i,
   input  logic [TAG_W-1:0]           wake1_tag_i,
   output logic                       iss0_valid_o,
   output logic                       iss1_valid_o,
   input  logic                       iss0_ready_i,
   input  logic                       iss1_ready_i,
   output logic [PAYLOAD_W-1:0]       iss0_payload_o,
   output logic [PAYLOAD_W-1:0]       iss1_payload_o,
   output logic [TAG_W-1:0]           iss0_src0_tag_o,
   output logic [TAG_W-1:0]           iss0_src1_tag_o,
   output logic [TAG_W-1:0]           iss1_src0_tag_o,
   output logic [TAG_W-1:0]           iss1_src1_tag_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = $clog2(DEPTH);

   // Entry storage; index 0 is the oldest, valid entries are contiguous.
   logic [DEPTH-1:0]     valid_q, valid_d;
   logic [DEPTH-1:0]     s0_rdy_q, s0_rdy_d;
   logic [DEPTH-1:0]     s1_rdy_q, s1_rdy_d;
   logic [TAG_W-1:0]     s0_tag_q [DEPTH];
   logic [TAG_W-1:0]     s0_tag_d [DEPTH];
   logic [TAG_W-1:0]     s1_tag_q [DEPTH];
   logic [TAG_W-1:0]     s1_tag_d [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];
   logic [PAYLOAD_W-1:0] payload_d [DEPTH];
   logic [CNT_W-1:0]     count_q, count_d;

   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] wake_s0;
   logic [DEPTH-1:0] wake_s1;
   logic [DEPTH-1:0] remove;
   logic             found0, found1;
   logic [IDX_W-1:0] sel0, sel1;
   logic             rm0, rm1;
   logic             enq_fire;
   logic             wake_enq0, wake_enq1;
   logic [CNT_W-1:0] wr_pos;

   // Per-entry readiness (registered bits only), wakeup matches and removal flags.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign ready[gi]   = valid_q[gi] & s0_rdy_q[gi] & s1_rdy_q[gi];
         assign wake_s0[gi] = (wake0_en_i && (wake0_tag_i == s0_tag_q[gi])) ||
                              (wake1_en_i && (wake1_tag_i == s0_tag_q[gi]));
         assign wake_s1[gi] = (wake0_en_i && (wake0_tag_i == s1_tag_q[gi])) ||
                              (wake1_en_i && (wake1_tag_i == s1_tag_q[gi]));
         assign remove[gi]  = (rm0 && (sel0 == IDX_W'(gi))) ||
                              (rm1 && (sel1 == IDX_W'(gi)));
      end
   endgenerate

   // The op arriving this cycle sees the same broadcasts as stored entries.
   assign wake_enq0 = (wake0_en_i && (wake0_tag_i == enq_src0_tag_i)) ||
                      (wake1_en_i && (wake1_tag_i == enq_src0_tag_i));
   assign wake_enq1 = (wake0_en_i && (wake0_tag_i == enq_src1_tag_i)) ||
                      (wake1_en_i && (wake1_tag_i == enq_src1_tag_i));

   // Room is judged from the registered count only; same-cycle issues are not credited.
   assign enq_ready_o = (count_q < CNT_W'(DEPTH));
   assign enq_fire    = enq_valid_i & enq_ready_o;
   assign count_o     = count_q;
   assign rm0         = iss0_valid_o & iss0_ready_i;
   assign rm1         = iss1_valid_o & iss1_ready_i;

   // Oldest-first select: port 0 gets the first ready entry, port 1 the next one.
   always_comb begin
      found0 = 1'b0;
      found1 = 1'b0;
      sel0   = '0;
      sel1   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i]) begin
            if (!found0) begin
               found0 = 1'b1;
               sel0   = IDX_W'(i);
            end else if (!found1) begin
               found1 = 1'b1;
               sel1   = IDX_W'(i);
            end
         end
      end
   end

   // Issue ports: driven from registered state; flush only masks the valids.
   always_comb begin
      iss0_valid_o    = found0 & ~flush_i;
      iss1_valid_o    = found1 & ~flush_i;
      iss0_payload_o  = found0 ? payload_q[sel0] : '0;
      iss0_src0_tag_o = found0 ? s0_tag_q[sel0]  : '0;
      iss0_src1_tag_o = found0 ? s1_tag_q[sel0]  : '0;
      iss1_payload_o  = found1 ? payload_q[sel1] : '0;
      iss1_src0_tag_o = found1 ? s0_tag_q[sel1]  : '0;
      iss1_src1_tag_o = found1 ? s1_tag_q[sel1]  : '0;
   end

   // Next state: pack survivors downward (with wakeup applied), then append the new op.
   always_comb begin
      valid_d   = '0;
      s0_rdy_d  = '0;
      s1_rdy_d  = '0;
      s0_tag_d  = s0_tag_q;
      s1_tag_d  = s1_tag_q;
      payload_d = payload_q;
      wr_pos    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && !remove[i]) begin
            valid_d[wr_pos[IDX_W-1:0]]   = 1'b1;
            s0_tag_d[wr_pos[IDX_W-1:0]]  = s0_tag_q[i];
            s1_tag_d[wr_pos[IDX_W-1:0]]  = s1_tag_q[i];
            s0_rdy_d[wr_pos[IDX_W-1:0]]  = s0_rdy_q[i] | wake_s0[i];
            s1_rdy_d[wr_pos[IDX_W-1:0]]  = s1_rdy_q[i] | wake_s1[i];
            payload_d[wr_pos[IDX_W-1:0]] = payload_q[i];
            wr_pos = wr_pos + CNT_W'(1);
         end
      end
      // enq_fire implies count_q < DEPTH, so wr_pos is a legal index here.
      if (enq_fire) begin
         valid_d[wr_pos[IDX_W-1:0]]   = 1'b1;
         s0_tag_d[wr_pos[IDX_W-1:0]]  = enq_src0_tag_i;
         s1_tag_d[wr_pos[IDX_W-1:0]]  = enq_src1_tag_i;
         s0_rdy_d[wr_pos[IDX_W-1:0]]  = enq_src0_rdy_i | wake_enq0;
         s1_rdy_d[wr_pos[IDX_W-1:0]]  = enq_src1_rdy_i | wake_enq1;
         payload_d[wr_pos[IDX_W-1:0]] = enq_payload_i;
         wr_pos = wr_pos + CNT_W'(1);
      end
      count_d = wr_pos;
      if (flush_i) begin
         valid_d = '0;
         count_d = '0;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= '0;
         s0_rdy_q <= '0;
         s1_rdy_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            s0_tag_q[i]  <= '0;
            s1_tag_q[i]  <= '0;
            payload_q[i] <= '0;
         end
      end else begin
         valid_q   <= valid_d;
         s0_rdy_q  <= s0_rdy_d;
         s1_rdy_q  <= s1_rdy_d;
         count_q   <= count_d;
         s0_tag_q  <= s0_tag_d;
         s1_tag_q  <= s1_tag_d;
         payload_q <= payload_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_alu_issue_queue;

   localparam int DEPTH = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         fl = 1'b0;
   logic         ev = 1'b0;
   logic [5:0]   et0 = '0, et1 = '0;
   logic         er0 = 1'b0, er1 = 1'b0;
   logic [127:0] epl = '0;
   logic         w0 = 1'b0, w1 = 1'b0;
   logic [5:0]   wt0 = '0, wt1 = '0;
   logic         ir0 = 1'b0, ir1 = 1'b0;

   logic         enq_ready;
   logic         v0, v1;
   logic [127:0] p0, p1;
   logic [5:0]   t00, t01, t10, t11;
   logic [3:0]   cnt;

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .PAYLOAD_W(128)) dut (
      .clk(clk), .rst(rst), .flush_i(fl),
      .enq_valid_i(ev), .enq_ready_o(enq_ready),
      .enq_src0_tag_i(et0), .enq_src1_tag_i(et1),
      .enq_src0_rdy_i(er0), .enq_src1_rdy_i(er1),
      .enq_payload_i(epl),
      .wake0_en_i(w0), .wake1_en_i(w1), .wake0_tag_i(wt0), .wake1_tag_i(wt1),
      .iss0_valid_o(v0), .iss1_valid_o(v1),
      .iss0_ready_i(ir0), .iss1_ready_i(ir1),
      .iss0_payload_o(p0), .iss1_payload_o(p1),
      .iss0_src0_tag_o(t00), .iss0_src1_tag_o(t01),
      .iss1_src0_tag_o(t10), .iss1_src1_tag_o(t11),
      .count_o(cnt)
   );

   always #5 clk = ~clk;

   // Reference model: a plain age-ordered list of waiting ops.
   typedef struct {
      logic [5:0]   t0;
      bit           r0;
      logic [5:0]   t1;
      bit           r1;
      logic [127:0] pl;
   } ent_t;
   ent_t mq[$];

   typedef struct {
      bit           enq;
      logic [127:0] pl;
      logic [5:0]   t0;
      bit           r0;
      logic [5:0]   t1;
      bit           r1;
      bit           w0;
      logic [5:0]   wt0;
      bit           w1;
      logic [5:0]   wt1;
      bit           ir0;
      bit           ir1;
      bit           fl;
      bit           ev0;
      logic [127:0] ep0;
      bit           ev1;
      logic [127:0] ep1;
      int           ecnt;
   } vec_t;
   vec_t tbl[16];

   function automatic vec_t mk(input int enq, pl, t0, r0, t1, r1, a0, at0, a1, at1,
                               i0, i1, f, x0, xp0, x1, xp1, xc);
      vec_t v;
      v.enq = enq[0]; v.pl = 128'(pl);
      v.t0 = 6'(t0); v.r0 = r0[0]; v.t1 = 6'(t1); v.r1 = r1[0];
      v.w0 = a0[0]; v.wt0 = 6'(at0); v.w1 = a1[0]; v.wt1 = 6'(at1);
      v.ir0 = i0[0]; v.ir1 = i1[0]; v.fl = f[0];
      v.ev0 = x0[0]; v.ep0 = 128'(xp0); v.ev1 = x1[0]; v.ep1 = 128'(xp1);
      v.ecnt = xc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic bit hit(input logic [5:0] t);
      return (w0 && wt0 == t) || (w1 && wt1 == t);
   endfunction

   function automatic void pick(output int i0, output int i1);
      i0 = -1;
      i1 = -1;
      for (int i = 0; i < mq.size(); i++) begin
         if (mq[i].r0 && mq[i].r1) begin
            if (i0 < 0) i0 = i;
            else if (i1 < 0) i1 = i;
         end
      end
   endfunction

   task automatic model_check();
      int i0, i1;
      bit x0, x1;
      pick(i0, i1);
      x0 = (i0 >= 0) && !fl;
      x1 = (i1 >= 0) && !fl;
      chk("count", 128'(cnt), 128'(mq.size()));
      chk("enq_ready", 128'(enq_ready), 128'(mq.size() < DEPTH));
      chk("iss0_valid", 128'(v0), 128'(x0));
      chk("iss1_valid", 128'(v1), 128'(x1));
      if (x0) begin
         chk("iss0_payload", p0, mq[i0].pl);
         chk("iss0_src0_tag", 128'(t00), 128'(mq[i0].t0));
         chk("iss0_src1_tag", 128'(t01), 128'(mq[i0].t1));
      end
      if (x1) begin
         chk("iss1_payload", p1, mq[i1].pl);
         chk("iss1_src0_tag", 128'(t10), 128'(mq[i1].t0));
         chk("iss1_src1_tag", 128'(t11), 128'(mq[i1].t1));
      end
   endtask

   function automatic void model_update();
      int i0, i1;
      bit x0, x1;
      ent_t e;
      ent_t nq[$];
      pick(i0, i1);
      x0 = (i0 >= 0) && !fl;
      x1 = (i1 >= 0) && !fl;
      if (fl) begin
         mq.delete();
         return;
      end
      for (int i = 0; i < mq.size(); i++) begin
         if (!((x0 && ir0 && i == i0) || (x1 && ir1 && i == i1))) begin
            e = mq[i];
            e.r0 = e.r0 | hit(e.t0);
            e.r1 = e.r1 | hit(e.t1);
            nq.push_back(e);
         end
      end
      if (ev && mq.size() < DEPTH) begin
         e.t0 = et0; e.r0 = er0 | hit(et0);
         e.t1 = et1; e.r1 = er1 | hit(et1);
         e.pl = epl;
         nq.push_back(e);
      end
      mq = nq;
   endfunction

   // One clock: optional model comparison, model advance, then the edge.
   task automatic step(input bit use_model);
      #1;
      if (use_model) model_check();
      $display("cyc %0d: enq=%0b rdy=%0b fl=%0b iss0=%0b/%0b iss1=%0b/%0b cnt=%0d",
               cyc, ev, enq_ready, fl, v0, ir0, v1, ir1, cnt);
      model_update();
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      ev = 1'b0; fl = 1'b0; w0 = 1'b0; w1 = 1'b0; ir0 = 1'b0; ir1 = 1'b0;
   endtask

   task automatic drive_enq(input logic [127:0] pl, input logic [5:0] a0, input logic b0,
                            input logic [5:0] a1, input logic b1);
      ev = 1'b1; epl = pl; et0 = a0; er0 = b0; et1 = a1; er1 = b1;
   endtask

   initial begin
      //            enq pl    t0 r0 t1 r1 w0 wt0 w1 wt1 ir0 ir1 fl ev0 ep0   ev1 ep1  cnt
      tbl[0]  = mk(0, 0,     0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0,  0,    0,  0,    0);
      tbl[1]  = mk(1, 'h0A,  1, 1, 2, 1, 0, 0,  0, 0,  1,  1,  0, 0,  0,    0,  0,    0);
      tbl[2]  = mk(0, 0,     0, 0, 0, 0, 0, 0,  0, 0,  1,  1,  0, 1,  'h0A, 0,  0,    1);
      tbl[3]  = mk(0, 0,     0, 0, 0, 0, 0, 0,  0, 0,  1,  1,  0, 0,  0,    0,  0,    0);
      tbl[4]  = mk(1, 'h11,  5, 0, 7, 1, 0, 0,  0, 0,  1,  1,  0, 0,  0,    0,  0,    0);
      tbl[5]  = mk(1, 'h22,  0, 1, 0, 1, 0, 0,  0, 0,  1,  1,  0, 0,  0,    0,  0,    1);
      tbl[6]  = mk(0, 0,     0, 0, 0, 0, 1, 5,  0, 0,  1,  1,  0, 1,  'h22, 0,  0,    2);
      tbl[7]  = mk(0, 0,     0, 0, 0, 0, 0, 0,  0, 0,  1,  1,  0, 1,  'h11, 0,  0,    1);
      tbl[8]  = mk(1, 'h33,  3, 1, 9, 0, 0, 0,  1, 9,  1,  1,  0, 0,  0,    0,  0,    0);
      tbl[9]  = mk(0, 0,     0, 0, 0, 0, 0, 0,  0, 0,  1,  1,  0, 1,  'h33, 0,  0,    1);
      tbl[10] = mk(1, 'h44,  0, 1, 0, 1, 0, 0,  0, 0,  0,  0,  0, 0,  0,    0,  0,    0);
      tbl[11] = mk(1, 'h55,  0, 1, 0, 1, 0, 0,  0, 0,  1,  1,  1, 0,  0,    0,  0,    1);
      tbl[12] = mk(1, 'h66,  0, 1, 0, 1, 0, 0,  0, 0,  0,  0,  0, 0,  0,    0,  0,    0);
      tbl[13] = mk(1, 'h77,  0, 1, 0, 1, 0, 0,  0, 0,  0,  0,  0, 1,  'h66, 0,  0,    1);
      tbl[14] = mk(0, 0,     0, 0, 0, 0, 0, 0,  0, 0,  1,  1,  0, 1,  'h66, 1,  'h77, 2);
      tbl[15] = mk(0, 0,     0, 0, 0, 0, 0, 0,  0, 0,  0,  0,  0, 0,  0,    0,  0,    0);

      // Reset values.
      #1;
      chk("rst_count", 128'(cnt), 128'(0));
      chk("rst_enq_ready", 128'(enq_ready), 128'(1));
      chk("rst_iss0_valid", 128'(v0), 128'(0));
      chk("rst_iss1_valid", 128'(v1), 128'(0));
      chk("rst_iss0_payload", p0, 128'(0));
      chk("rst_iss1_src0_tag", 128'(t10), 128'(0));
      @(negedge clk);
      rst = 1'b0;

      // Directed vector table.
      for (int k = 0; k < 16; k++) begin
         ev = tbl[k].enq; epl = tbl[k].pl;
         et0 = tbl[k].t0; er0 = tbl[k].r0; et1 = tbl[k].t1; er1 = tbl[k].r1;
         w0 = tbl[k].w0; wt0 = tbl[k].wt0; w1 = tbl[k].w1; wt1 = tbl[k].wt1;
         ir0 = tbl[k].ir0; ir1 = tbl[k].ir1; fl = tbl[k].fl;
         #1;
         chk($sformatf("tbl%0d_iss0_valid", k), 128'(v0), 128'(tbl[k].ev0));
         chk($sformatf("tbl%0d_iss1_valid", k), 128'(v1), 128'(tbl[k].ev1));
         chk($sformatf("tbl%0d_count", k), 128'(cnt), 128'(tbl[k].ecnt));
         chk($sformatf("tbl%0d_enq_ready", k), 128'(enq_ready), 128'(tbl[k].ecnt < DEPTH));
         if (tbl[k].ev0) chk($sformatf("tbl%0d_iss0_payload", k), p0, tbl[k].ep0);
         if (tbl[k].ev1) chk($sformatf("tbl%0d_iss1_payload", k), p1, tbl[k].ep1);
         step(1'b0);
      end
      idle();

      // Fill all entries not ready; entries 2 and 6 share source tag 30.
      for (int k = 0; k < DEPTH; k++) begin
         drive_enq(128'(256 + k), (k == 2 || k == 6) ? 6'd30 : 6'(20 + k), 1'b0, 6'd0, 1'b1);
         step(1'b1);
      end
      drive_enq(128'h999, 6'd1, 1'b1, 6'd1, 1'b1);
      w0 = 1'b1; wt0 = 6'd30;
      #1;
      chk("full_enq_ready", 128'(enq_ready), 128'(0));
      chk("full_count", 128'(cnt), 128'(8));
      step(1'b1);
      w0 = 1'b0; ir0 = 1'b1; ir1 = 1'b1;
      #1;
      chk("shared_wake_iss0", p0, 128'(258));
      chk("shared_wake_iss1", p1, 128'(262));
      chk("full_dual_issue_enq_ready", 128'(enq_ready), 128'(0));
      step(1'b1);
      idle();
      #1;
      chk("after_dual_issue_count", 128'(cnt), 128'(6));
      step(1'b1);
      w0 = 1'b1; wt0 = 6'd20; w1 = 1'b1; wt1 = 6'd21; step(1'b1);
      wt0 = 6'd23; wt1 = 6'd24; step(1'b1);
      wt0 = 6'd25; wt1 = 6'd27; step(1'b1);
      w0 = 1'b0; w1 = 1'b0; ir0 = 1'b1; ir1 = 1'b1;
      #1;
      chk("age_order_iss0", p0, 128'(256));
      chk("age_order_iss1", p1, 128'(257));
      for (int k = 0; k < 4; k++) step(1'b1);
      idle();

      // Port 0 stalled, port 1 accepting, three ready entries X<Y<Z.
      drive_enq(128'h501, 6'd1, 1'b1, 6'd1, 1'b1); step(1'b1);
      drive_enq(128'h502, 6'd1, 1'b1, 6'd1, 1'b1); step(1'b1);
      drive_enq(128'h503, 6'd1, 1'b1, 6'd1, 1'b1); step(1'b1);
      ev = 1'b0; ir0 = 1'b0; ir1 = 1'b1;
      #1;
      chk("stall_iss0_first", p0, 128'h501);
      chk("stall_iss1_first", p1, 128'h502);
      step(1'b1);
      #1;
      chk("stall_iss0_held", p0, 128'h501);
      chk("stall_iss1_next", p1, 128'h503);
      step(1'b1);
      ir0 = 1'b1; step(1'b1);
      idle(); step(1'b1);

      // Flush with five ready entries and an enqueue offered.
      for (int k = 0; k < 5; k++) begin
         drive_enq(128'(1536 + k), 6'd2, 1'b1, 6'd3, 1'b1);
         step(1'b1);
      end
      drive_enq(128'h777, 6'd2, 1'b1, 6'd3, 1'b1);
      fl = 1'b1; ir0 = 1'b1; ir1 = 1'b1;
      #1;
      chk("flush_iss0_valid", 128'(v0), 128'(0));
      chk("flush_iss1_valid", 128'(v1), 128'(0));
      chk("flush_pre_count", 128'(cnt), 128'(5));
      step(1'b1);
      idle();
      #1;
      chk("flush_post_count", 128'(cnt), 128'(0));
      chk("flush_post_iss0_valid", 128'(v0), 128'(0));
      step(1'b1);

      // Randomized traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         ev  = ($urandom_range(0, 9) < 7);
         et0 = 6'($urandom_range(0, 15)); er0 = 1'($urandom_range(0, 1));
         et1 = 6'($urandom_range(0, 15)); er1 = 1'($urandom_range(0, 1));
         epl = {$urandom, $urandom, $urandom, $urandom};
         w0  = ($urandom_range(0, 2) == 0); wt0 = 6'($urandom_range(0, 15));
         w1  = ($urandom_range(0, 2) == 0); wt1 = 6'($urandom_range(0, 15));
         ir0 = ($urandom_range(0, 3) != 0);
         ir1 = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 49) == 0);
         step(1'b1);
      end

      // Fill a few entries, then assert reset between clock edges.
      idle();
      for (int k = 0; k < 3; k++) begin
         drive_enq(128'(4096 + k), 6'd4, 1'b1, 6'd4, 1'b1);
         step(1'b1);
      end
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_count", 128'(cnt), 128'(0));
      chk("async_rst_enq_ready", 128'(enq_ready), 128'(1));
      chk("async_rst_iss0_valid", 128'(v0), 128'(0));
      chk("async_rst_iss0_payload", p0, 128'(0));
      mq.delete();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1);
      step(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
